// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: hazard controller state and per-stage
// pipeline-register control pair.
package rv32i_types;

   typedef enum logic {
      RUN    = 1'b0,
      SQUASH = 1'b1
   } hazard_state_t;

   typedef struct packed {
      logic load;
      logic flush;
   } stage_ctrl_t;

   // Pipeline registers honour flush only when load=1, so a bubble is
   // load+flush and a hold is load=0 with flush parked at 0.
   localparam stage_ctrl_t CTRL_LOAD   = stage_ctrl_t'(2'b10);
   localparam stage_ctrl_t CTRL_HOLD   = stage_ctrl_t'(2'b00);
   localparam stage_ctrl_t CTRL_BUBBLE = stage_ctrl_t'(2'b11);
   localparam stage_ctrl_t CTRL_OFF    = stage_ctrl_t'(2'b00);

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: the ID instruction reads a register that the
// load currently in EX has not yet produced. x0 never creates a dependency.
module load_use_detect (
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_use_rs1,
   input  logic       id_use_rs2,
   input  logic [4:0] ex_rd,
   input  logic       ex_mem_read,
   output logic       load_use
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
   assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
   assign load_use = ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage RV32I pipeline. Drives the
// load/flush pair of every pipeline register plus the PC enable, tracks a
// wrong-path fetch still in flight after a redirect, and counts stall/flush
// activity.
module pipeline_hazard_ctrl
   import rv32i_types::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             imem_busy,
   input  logic             dmem_busy,
   input  logic             md_busy,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_br_taken,
   output logic             pc_load,
   output logic             if_id_load,
   output logic             if_id_flush,
   output logic             id_ex_load,
   output logic             id_ex_flush,
   output logic             ex_mem_load,
   output logic             ex_mem_flush,
   output logic             mem_wb_load,
   output logic             mem_wb_flush,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count,
   output logic [CNT_W-1:0] squash_count
);

   hazard_state_t    state_q, state_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;
   logic [CNT_W-1:0] squash_count_q, squash_count_d;

   logic        load_use;
   logic        pc_load_c;
   logic        flush_inc;
   logic        squash_inc;
   stage_ctrl_t if_id_c, id_ex_c, ex_mem_c, mem_wb_c;

   load_use_detect u_load_use_detect (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .ex_rd       (ex_rd),
      .ex_mem_read (ex_mem_read),
      .load_use    (load_use)
   );

   // Priority encoder and squash FSM next-state: first true condition wins.
   always_comb begin
      pc_load_c  = 1'b1;
      if_id_c    = CTRL_LOAD;
      id_ex_c    = CTRL_LOAD;
      ex_mem_c   = CTRL_LOAD;
      mem_wb_c   = CTRL_LOAD;
      flush_inc  = 1'b0;
      squash_inc = 1'b0;
      state_d    = state_q;

      if (rst) begin
         pc_load_c = 1'b0;
         if_id_c   = CTRL_OFF;
         id_ex_c   = CTRL_OFF;
         ex_mem_c  = CTRL_OFF;
         mem_wb_c  = CTRL_OFF;
         state_d   = RUN;
      end else if (dmem_busy) begin
         // MEM cannot retire: freeze everything upstream, feed WB a bubble.
         pc_load_c = 1'b0;
         if_id_c   = CTRL_HOLD;
         id_ex_c   = CTRL_HOLD;
         ex_mem_c  = CTRL_HOLD;
         mem_wb_c  = CTRL_BUBBLE;
      end else if (md_busy) begin
         pc_load_c = 1'b0;
         if_id_c   = CTRL_HOLD;
         id_ex_c   = CTRL_HOLD;
         ex_mem_c  = CTRL_BUBBLE;
      end else if ((state_q == SQUASH) && !imem_busy) begin
         // The stale wrong-path fetch lands now: drop it and let the PC
         // advance from the redirect target.
         pc_load_c  = 1'b1;
         if_id_c    = CTRL_BUBBLE;
         squash_inc = 1'b1;
         state_d    = RUN;
         if (ex_br_taken) begin
            id_ex_c   = CTRL_BUBBLE;
            flush_inc = 1'b1;
         end
      end else if (ex_br_taken) begin
         // Redirect outranks load-use: the ID instruction is wrong-path.
         pc_load_c = 1'b1;
         if_id_c   = CTRL_BUBBLE;
         id_ex_c   = CTRL_BUBBLE;
         flush_inc = 1'b1;
         if (imem_busy) begin
            state_d = SQUASH;
         end
      end else if (load_use) begin
         pc_load_c = 1'b0;
         if_id_c   = CTRL_HOLD;
         id_ex_c   = CTRL_BUBBLE;
      end else if (imem_busy) begin
         pc_load_c = 1'b0;
         if_id_c   = CTRL_BUBBLE;
      end
   end

   // Free-running counters, wrapping naturally at 2^CNT_W.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      squash_count_d = squash_count_q;
      if (!pc_load_c) begin
         stall_cycles_d = stall_cycles_q + 1'b1;
      end
      if (flush_inc) begin
         flush_count_d = flush_count_q + 1'b1;
      end
      if (squash_inc) begin
         squash_count_d = squash_count_q + 1'b1;
      end
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= RUN;
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
         squash_count_q <= '0;
      end else begin
         state_q        <= state_d;
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
         squash_count_q <= squash_count_d;
      end
   end

   assign pc_load      = pc_load_c;
   assign if_id_load   = if_id_c.load;
   assign if_id_flush  = if_id_c.flush;
   assign id_ex_load   = id_ex_c.load;
   assign id_ex_flush  = id_ex_c.flush;
   assign ex_mem_load  = ex_mem_c.load;
   assign ex_mem_flush = ex_mem_c.flush;
   assign mem_wb_load  = mem_wb_c.load;
   assign mem_wb_flush = mem_wb_c.flush;
   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
   assign squash_count = squash_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed control vectors
// and counter values.
module tb_pipeline_hazard_ctrl;

   logic        clk;
   logic        rst;
   logic        imem_busy, dmem_busy, md_busy;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken;
   logic        pc_load;
   logic        if_id_load, if_id_flush, id_ex_load, id_ex_flush;
   logic        ex_mem_load, ex_mem_flush, mem_wb_load, mem_wb_flush;
   logic [31:0] stall_cycles, flush_count, squash_count;

   int tests_run;
   int tests_failed;
   int exp_stall, exp_flush, exp_squash;

   // {pc, if_id L/F, id_ex L/F, ex_mem L/F, mem_wb L/F}
   localparam logic [8:0] V_RST  = 9'b0_00_00_00_00;
   localparam logic [8:0] V_DEF  = 9'b1_10_10_10_10;
   localparam logic [8:0] V_DMEM = 9'b0_00_00_00_11;
   localparam logic [8:0] V_MD   = 9'b0_00_00_11_10;
   localparam logic [8:0] V_BR   = 9'b1_11_11_10_10;
   localparam logic [8:0] V_LU   = 9'b0_00_11_10_10;
   localparam logic [8:0] V_IMEM = 9'b0_11_10_10_10;
   localparam logic [8:0] V_SQX  = 9'b1_11_10_10_10;

   logic [8:0] ctrl;
   assign ctrl = {pc_load, if_id_load, if_id_flush, id_ex_load, id_ex_flush,
                  ex_mem_load, ex_mem_flush, mem_wb_load, mem_wb_flush};

   pipeline_hazard_ctrl #(.CNT_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_busy    (imem_busy),
      .dmem_busy    (dmem_busy),
      .md_busy      (md_busy),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_use_rs1   (id_use_rs1),
      .id_use_rs2   (id_use_rs2),
      .ex_rd        (ex_rd),
      .ex_mem_read  (ex_mem_read),
      .ex_br_taken  (ex_br_taken),
      .pc_load      (pc_load),
      .if_id_load   (if_id_load),
      .if_id_flush  (if_id_flush),
      .id_ex_load   (id_ex_load),
      .id_ex_flush  (id_ex_flush),
      .ex_mem_load  (ex_mem_load),
      .ex_mem_flush (ex_mem_flush),
      .mem_wb_load  (mem_wb_load),
      .mem_wb_flush (mem_wb_flush),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count),
      .squash_count (squash_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      imem_busy = 0; dmem_busy = 0; md_busy = 0;
      id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      ex_rd = 0; ex_mem_read = 0; ex_br_taken = 0;
   endtask

   // Inputs are already applied; check combinational controls mid-cycle,
   // then let the edge happen and settle.
   task automatic cyc(input string tag, input logic [8:0] exp);
      @(negedge clk);
      chk(tag, 32'(ctrl), 32'(exp));
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cnt(input string tag);
      chk({tag, ".stall"},  stall_cycles, exp_stall);
      chk({tag, ".flush"},  flush_count,  exp_flush);
      chk({tag, ".squash"}, squash_count, exp_squash);
   endtask

   task automatic chk_state(input string tag, input logic exp);
      chk({tag, ".state"}, 32'(dut.state_q), 32'(exp));
   endtask

   initial begin
      tests_run = 0; tests_failed = 0;
      exp_stall = 0; exp_flush = 0; exp_squash = 0;
      clear_inputs();
      rst = 1'b1;
      @(posedge clk); #1;
      cyc("rst_outputs", V_RST);
      @(posedge clk); #1;
      rst = 1'b0;
      chk_cnt("after_rst");
      chk_state("after_rst", 1'b0);
      cyc("default", V_DEF);
      chk_cnt("default");

      // load-use via rs1
      ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
      cyc("lu_rs1", V_LU); exp_stall = 1;
      chk_cnt("lu_rs1");
      // x0 destination never stalls
      ex_rd = 0; id_rs1 = 0;
      cyc("lu_x0", V_DEF);
      chk_cnt("lu_x0");
      // load-use via rs2; then rs2 match without use
      ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; id_use_rs1 = 0; id_rs1 = 3;
      cyc("lu_rs2", V_LU); exp_stall = 2;
      id_use_rs2 = 0;
      cyc("lu_nouse", V_DEF);
      // non-load in EX
      id_use_rs2 = 1; ex_mem_read = 0;
      cyc("lu_noload", V_DEF);
      chk_cnt("lu_group");
      clear_inputs();

      // dmem_busy masks a pending redirect for 3 cycles
      dmem_busy = 1; ex_br_taken = 1;
      for (int i = 0; i < 3; i++) cyc("dmem_freeze", V_DMEM);
      exp_stall = 5;
      chk_cnt("dmem_freeze");
      dmem_busy = 0;
      cyc("br_after_dmem", V_BR); exp_flush = 1;
      chk_cnt("br_after_dmem");
      // redirect beats load-use
      ex_mem_read = 1; ex_rd = 9; id_rs1 = 9; id_use_rs1 = 1;
      cyc("br_vs_lu", V_BR); exp_flush = 2;
      chk_cnt("br_vs_lu");
      clear_inputs();

      // redirect during outstanding fetch -> squash
      ex_br_taken = 1; imem_busy = 1;
      cyc("br_imem", V_BR); exp_flush = 3;
      chk_state("br_imem", 1'b1);
      ex_br_taken = 0;
      for (int i = 0; i < 2; i++) cyc("sq_wait", V_IMEM);
      exp_stall = 7;
      chk_state("sq_wait", 1'b1);
      chk_cnt("sq_wait");
      imem_busy = 0;
      cyc("sq_exit", V_SQX); exp_squash = 1;
      chk_state("sq_exit", 1'b0);
      chk_cnt("sq_exit");
      cyc("sq_after", V_DEF);

      // dmem_busy overrides the squash exit
      ex_br_taken = 1; imem_busy = 1;
      cyc("br_imem2", V_BR); exp_flush = 4;
      ex_br_taken = 0; imem_busy = 0; dmem_busy = 1;
      cyc("sq_dmem", V_DMEM); exp_stall = 8;
      chk_state("sq_dmem", 1'b1);
      dmem_busy = 0;
      cyc("sq_exit2", V_SQX); exp_squash = 2;
      chk_state("sq_exit2", 1'b0);
      chk_cnt("sq_exit2");

      // second redirect in SQUASH stays in SQUASH
      ex_br_taken = 1; imem_busy = 1;
      cyc("br_sq_a", V_BR);
      cyc("br_sq_b", V_BR); exp_flush = 6;
      chk_state("br_sq_b", 1'b1);
      ex_br_taken = 0; imem_busy = 0;
      cyc("sq_exit3", V_SQX); exp_squash = 3;
      chk_cnt("sq_exit3");

      // multi-cycle EX unit
      md_busy = 1;
      for (int i = 0; i < 4; i++) cyc("md_busy", V_MD);
      exp_stall = 12;
      chk_cnt("md_busy");
      md_busy = 0;
      // fetch-only stall
      imem_busy = 1;
      cyc("imem_only", V_IMEM); exp_stall = 13;
      chk_cnt("imem_only");
      imem_busy = 0;

      // reset while in SQUASH
      ex_br_taken = 1; imem_busy = 1;
      cyc("br_pre_rst", V_BR);
      chk_state("br_pre_rst", 1'b1);
      rst = 1'b1;
      cyc("rst_mid_sq", V_RST);
      rst = 1'b0;
      clear_inputs();
      exp_stall = 0; exp_flush = 0; exp_squash = 0;
      chk_state("post_rst", 1'b0);
      chk_cnt("post_rst");
      cyc("post_rst_def", V_DEF);
      chk_cnt("post_rst_def");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
